switch_mem_cfg: RTL and testbench
=================================

# switch_mem_cfg

Parametrised configuration register bank for the switch's memory-configuration port. It holds one destination address per output port and accepts single-cycle writes and reads over the mem_* bus. Active entries drive the switch's port-address comparators. It generalises the fixed 4-port/8-bit configuration path with configurable width and depth, read-back, write locking, address-range errors and duplicate-address detection.

## Interface
Parameters:
- NUM_PORTS, 4, number of entries (switch output ports); 2..16
- ADDR_W, 2, mem_addr width; must satisfy 2**ADDR_W >= NUM_PORTS
- DATA_W, 8, entry width; must satisfy DATA_W >= ADDR_W

Ports:
- clock  in  1  single clock, all state on posedge
- reset  in  1  asynchronous, active-high
- mem_en  in  1  request strobe, one operation per cycle
- mem_rd_wr  in  1  1 = write, 0 = read
- mem_addr  in  ADDR_W  entry index
- mem_wdata  in  DATA_W  write data
- cfg_lock  in  1  high = writes rejected
- mem_rdata  out  DATA_W  read data
- mem_rvalid  out  1  one-cycle read-response strobe
- mem_err  out  1  one-cycle error strobe
- port_addr  out  NUM_PORTS*DATA_W  active entries, entry i at bits [i*DATA_W +: DATA_W]
- cfg_update  out  1  one-cycle pulse after an accepted write
- cfg_conflict  out  1  level; two or more entries hold equal values

## Operation
- Reset: entry i = i (zero-extended to DATA_W). mem_rdata = 0, mem_rvalid = 0, mem_err = 0, cfg_update = 0, cfg_conflict = 0. Reset takes effect immediately and can interrupt any operation. A write or read in flight is discarded, with no response.
- Accepted write: mem_en=1, mem_rd_wr=1, mem_addr < NUM_PORTS, cfg_lock=0. The entry loads mem_wdata at that edge, and cfg_update pulses in the next cycle.
- Rejected write: addr >= NUM_PORTS or cfg_lock=1. No entry changes, cfg_update stays 0, and mem_err pulses in the next cycle.
- Read: mem_en=1, mem_rd_wr=0. In the next cycle mem_rvalid=1 and mem_rdata = entry[mem_addr]. If addr >= NUM_PORTS, mem_rdata = 0 and mem_err = 1 in the same cycle as mem_rvalid. Reads are allowed while locked.
- mem_rdata holds its last value when mem_rvalid=0.
- cfg_conflict is registered from the current entries. It is 1 if any pair i≠j has entry[i]==entry[j], and it is recomputed every cycle.
- mem_en=0: no state change; all strobes are 0 in the next cycle.

## Timing
- Write issued in cycle t: port_addr and cfg_update change at t+1, and cfg_conflict reflects the new contents at t+2.
- Read issued in cycle t: response at t+1, latency 1. Back-to-back reads produce back-to-back responses.
- Read in cycle t+1 of an entry written in cycle t returns the new value, with no bypass hazard.
- cfg_lock is sampled in the same cycle as mem_en. A lock change takes effect on the next request.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- SWITCH_MEM_CFG_PARITY_EN defined:
  - Each entry stores an extra even-parity bit, computed at write time.
  - Added input parity_inject (1 bit): when high during an accepted write, the stored parity bit is inverted.
  - Added output mem_perr (1 bit, reset 0): pulses together with mem_rvalid when the stored parity of the read entry mismatches its data.
  - Reset entries carry correct parity.
  - port_addr is unaffected.
- Undefined: no parity storage, and neither the parity_inject nor the mem_perr port exists.

## Test plan
- Reset release, then read addr 0..3 -> rvalid 1 cycle after each request, rdata 0,1,2,3; cfg_conflict=0; port_addr=0x03020100.
- Write 0xA5 to addr 2, read addr 2 the next cycle -> cfg_update pulse at t+1, rdata 0xA5 at t+2, port_addr[23:16]=0xA5.
- cfg_lock=1, write 0x11 to addr 1 -> mem_err pulse at t+1, no cfg_update, read addr 1 returns 0x01.
- Write 0x03 to addr 0 (duplicates entry 3) -> cfg_conflict=1 from t+2; then write 0x07 to addr 0 -> cfg_conflict returns to 0 two cycles later.
- NUM_PORTS=3, ADDR_W=2: read addr 3 -> rvalid=1, rdata=0x00, mem_err=1; write addr 3 -> mem_err=1, no entry changes.
- Parity macro: write 0x5A to addr 1 with parity_inject=1, then read addr 1 -> rdata 0x5A with mem_perr=1; assert reset mid-read -> no rvalid, and all outputs return to reset values.

Source files
------------

// File: rtl/switch_mem_cfg_if.sv
// ---------------------------------------------------------------------------
// switch_mem_cfg_if
// Bus bundle for the switch memory-configuration port. It groups the request
// side (mem_en, mem_rd_wr, mem_addr, mem_wdata, cfg_lock) and the registered
// response/status side (mem_rdata, mem_rvalid, mem_err, port_addr,
// cfg_update, cfg_conflict).
//   master : the requester, drives requests and observes responses
//   slave  : the configuration bank (switch_mem_cfg)
// Optional macro SWITCH_MEM_CFG_PARITY_EN adds parity_inject (request side)
// and mem_perr (response side).
// ---------------------------------------------------------------------------
interface switch_mem_cfg_if #(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = 2,
    parameter int DATA_W    = 8
);
    logic                        mem_en;
    logic                        mem_rd_wr;
    logic [ADDR_W-1:0]           mem_addr;
    logic [DATA_W-1:0]           mem_wdata;
    logic                        cfg_lock;
    logic [DATA_W-1:0]           mem_rdata;
    logic                        mem_rvalid;
    logic                        mem_err;
    logic [NUM_PORTS*DATA_W-1:0] port_addr;
    logic                        cfg_update;
    logic                        cfg_conflict;
`ifdef SWITCH_MEM_CFG_PARITY_EN
    logic                        parity_inject;
    logic                        mem_perr;
`endif

    modport master (
        output mem_en, mem_rd_wr, mem_addr, mem_wdata, cfg_lock,
`ifdef SWITCH_MEM_CFG_PARITY_EN
        output parity_inject,
        input  mem_perr,
`endif
        input  mem_rdata, mem_rvalid, mem_err, port_addr, cfg_update, cfg_conflict
    );

    modport slave (
        input  mem_en, mem_rd_wr, mem_addr, mem_wdata, cfg_lock,
`ifdef SWITCH_MEM_CFG_PARITY_EN
        input  parity_inject,
        output mem_perr,
`endif
        output mem_rdata, mem_rvalid, mem_err, port_addr, cfg_update, cfg_conflict
    );
endinterface

// File: rtl/switch_mem_cfg.sv
// ---------------------------------------------------------------------------
// switch_mem_cfg
// Configuration register bank holding one destination address per switch
// output port. Single-cycle writes and reads over the mem_* bus, read-back
// with latency 1, write locking, out-of-range address errors and
// duplicate-address detection. Entries drive port_addr directly.
//
// Ports:
//   clock  : single clock, all state on posedge
//   reset  : asynchronous, active-high
//   bus    : switch_mem_cfg_if.slave
//            in  mem_en, mem_rd_wr (1=write), mem_addr, mem_wdata, cfg_lock
//            out mem_rdata, mem_rvalid, mem_err, port_addr (entry i at
//                [i*DATA_W +: DATA_W]), cfg_update, cfg_conflict
//
// Optional macro SWITCH_MEM_CFG_PARITY_EN: each entry keeps an even-parity
// bit (inverted by parity_inject on an accepted write), and mem_perr pulses
// with mem_rvalid when a read entry's stored parity disagrees with its data.
// ---------------------------------------------------------------------------
module switch_mem_cfg #(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = 2,
    parameter int DATA_W    = 8
) (
    input  logic            clock,
    input  logic            reset,
    switch_mem_cfg_if.slave bus
);

    logic [NUM_PORTS-1:0][DATA_W-1:0] entries_q, entries_d;
    logic [DATA_W-1:0]                rdata_q, rdata_d;
    logic                             rvalid_q, rvalid_d;
    logic                             err_q, err_d;
    logic                             update_q, update_d;
    logic                             conflict_q, conflict_d;

    logic                             addrInRange;
    logic                             writeReq;
    logic                             readReq;
    logic                             writeOk;
    logic [DATA_W-1:0]                rdSel;

`ifdef SWITCH_MEM_CFG_PARITY_EN
    logic [NUM_PORTS-1:0]             parity_q, parity_d;
    logic                             perr_q, perr_d;
    logic                             parSel;
`endif

    // NUM_PORTS always fits in ADDR_W+1 bits, so the widened compare is exact
    // even when NUM_PORTS == 2**ADDR_W.
    assign addrInRange = ({1'b0, bus.mem_addr} < (ADDR_W+1)'(NUM_PORTS));
    assign writeReq    = bus.mem_en &  bus.mem_rd_wr;
    assign readReq     = bus.mem_en & ~bus.mem_rd_wr;
    assign writeOk     = writeReq & addrInRange & ~bus.cfg_lock;

    // Read mux written as a decode loop so an out-of-range address simply
    // matches nothing and yields zero instead of indexing past the array.
    always_comb begin
        rdSel = '0;
`ifdef SWITCH_MEM_CFG_PARITY_EN
        parSel = 1'b0;
`endif
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (bus.mem_addr == ADDR_W'(i)) begin
                rdSel = entries_q[i];
`ifdef SWITCH_MEM_CFG_PARITY_EN
                parSel = parity_q[i];
`endif
            end
        end
    end

    // Duplicate detection over every distinct pair of current entries; the
    // result is registered, so it trails the entry contents by one cycle.
    always_comb begin
        conflict_d = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            for (int j = i + 1; j < NUM_PORTS; j++) begin
                if (entries_q[i] == entries_q[j]) begin
                    conflict_d = 1'b1;
                end
            end
        end
    end

    // Next-state for entries and response strobes. Strobes default low so an
    // idle cycle always produces a quiet response cycle; read data holds.
    always_comb begin
        entries_d = entries_q;
        rdata_d   = rdata_q;
        rvalid_d  = 1'b0;
        err_d     = 1'b0;
        update_d  = 1'b0;
`ifdef SWITCH_MEM_CFG_PARITY_EN
        parity_d  = parity_q;
        perr_d    = 1'b0;
`endif
        if (writeOk) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (bus.mem_addr == ADDR_W'(i)) begin
                    entries_d[i] = bus.mem_wdata;
`ifdef SWITCH_MEM_CFG_PARITY_EN
                    parity_d[i] = (^bus.mem_wdata) ^ bus.parity_inject;
`endif
                end
            end
            update_d = 1'b1;
        end else if (writeReq) begin
            err_d = 1'b1;
        end

        if (readReq) begin
            rvalid_d = 1'b1;
            rdata_d  = rdSel;
            err_d    = ~addrInRange;
`ifdef SWITCH_MEM_CFG_PARITY_EN
            perr_d   = addrInRange & ((^rdSel) != parSel);
`endif
        end
    end

    // State register. Reset reloads the identity mapping (entry i = i) and
    // drops any in-flight response.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                entries_q[i] <= DATA_W'(i);
`ifdef SWITCH_MEM_CFG_PARITY_EN
                parity_q[i]  <= ^(DATA_W'(i));
`endif
            end
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            err_q      <= 1'b0;
            update_q   <= 1'b0;
            conflict_q <= 1'b0;
`ifdef SWITCH_MEM_CFG_PARITY_EN
            perr_q     <= 1'b0;
`endif
        end else begin
            entries_q  <= entries_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            err_q      <= err_d;
            update_q   <= update_d;
            conflict_q <= conflict_d;
`ifdef SWITCH_MEM_CFG_PARITY_EN
            parity_q   <= parity_d;
            perr_q     <= perr_d;
`endif
        end
    end

    assign bus.port_addr    = entries_q;
    assign bus.mem_rdata    = rdata_q;
    assign bus.mem_rvalid   = rvalid_q;
    assign bus.mem_err      = err_q;
    assign bus.cfg_update   = update_q;
    assign bus.cfg_conflict = conflict_q;
`ifdef SWITCH_MEM_CFG_PARITY_EN
    assign bus.mem_perr     = perr_q;
`endif

endmodule

// File: tb/tb_switch_mem_cfg.sv
// ---------------------------------------------------------------------------
// tb_switch_mem_cfg
// Self-checking bench for switch_mem_cfg. A 4-entry instance is driven every
// cycle; each driven cycle pushes its expected response (strobes, read data,
// port_addr, cfg_conflict) into a queue that the negedge monitor pops when
// the response is due. A 3-entry instance covers out-of-range addresses.
// Honours SWITCH_MEM_CFG_PARITY_EN for parity_inject / mem_perr.
// ---------------------------------------------------------------------------
module tb_switch_mem_cfg;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    switch_mem_cfg_if #(.NUM_PORTS(4), .ADDR_W(2), .DATA_W(8)) bus4();
    switch_mem_cfg_if #(.NUM_PORTS(3), .ADDR_W(2), .DATA_W(8)) bus3();

    switch_mem_cfg #(.NUM_PORTS(4), .ADDR_W(2), .DATA_W(8)) dut4 (
        .clock (clock),
        .reset (reset),
        .bus   (bus4)
    );

    switch_mem_cfg #(.NUM_PORTS(3), .ADDR_W(2), .DATA_W(8)) dut3 (
        .clock (clock),
        .reset (reset),
        .bus   (bus3)
    );

    typedef struct {
        int          due;
        logic        rvalid;
        logic        err;
        logic        update;
        logic        perr;
        logic        conflict;
        logic [7:0]  rdata;
        logic [31:0] portAddr;
    } expT;

    expT        sbQ[$];
    int         checks = 0;
    int         errors = 0;
    int         cycle  = 0;
    bit         scoreOn = 1'b0;
    logic [7:0] modelEntry [4];
    logic       modelPar   [4];
    logic [7:0] lastRdata;

    // Cycle counter used to time-stamp expectations.
    always @(posedge clock) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                     tag, actual, expected, $time);
        end
    endtask

    function automatic logic modelConflict();
        logic c = 1'b0;
        for (int i = 0; i < 4; i++)
            for (int j = i + 1; j < 4; j++)
                if (modelEntry[i] == modelEntry[j]) c = 1'b1;
        return c;
    endfunction

    function automatic logic [31:0] modelPorts();
        return {modelEntry[3], modelEntry[2], modelEntry[1], modelEntry[0]};
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 4; i++) begin
            modelEntry[i] = 8'(i);
            modelPar[i]   = ^(8'(i));
        end
        lastRdata = 8'h00;
    endtask

    // Drives one request cycle on the 4-entry bus and queues its response.
    task automatic applyStimulus(input logic en, input logic rdwr,
                                 input logic [1:0] addr, input logic [7:0] wdata,
                                 input logic lock, input logic inj);
        expT e;
        @(posedge clock);
        #1;
        bus4.mem_en    = en;
        bus4.mem_rd_wr = rdwr;
        bus4.mem_addr  = addr;
        bus4.mem_wdata = wdata;
        bus4.cfg_lock  = lock;
`ifdef SWITCH_MEM_CFG_PARITY_EN
        bus4.parity_inject = inj;
`endif
        e.due      = cycle + 1;
        e.rvalid   = 1'b0;
        e.err      = 1'b0;
        e.update   = 1'b0;
        e.perr     = 1'b0;
        e.conflict = modelConflict();
        if (en && rdwr) begin
            if (!lock) begin
                modelEntry[addr] = wdata;
                modelPar[addr]   = (^wdata) ^ inj;
                e.update = 1'b1;
            end else begin
                e.err = 1'b1;
            end
        end else if (en) begin
            e.rvalid  = 1'b1;
            lastRdata = modelEntry[addr];
            e.perr    = ((^modelEntry[addr]) != modelPar[addr]);
        end
        e.rdata    = lastRdata;
        e.portAddr = modelPorts();
        sbQ.push_back(e);
    endtask

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
    endtask

    // Scoreboard monitor: compares every queued response on the cycle it is due.
    always @(negedge clock) begin
        expT e;
        if (scoreOn) begin
            while (sbQ.size() > 0 && sbQ[0].due <= cycle) begin
                e = sbQ.pop_front();
                checkOutput("dueCycle", cycle, e.due);
                checkOutput("rvalid",   {31'd0, bus4.mem_rvalid},   {31'd0, e.rvalid});
                checkOutput("err",      {31'd0, bus4.mem_err},      {31'd0, e.err});
                checkOutput("update",   {31'd0, bus4.cfg_update},   {31'd0, e.update});
                checkOutput("conflict", {31'd0, bus4.cfg_conflict}, {31'd0, e.conflict});
                checkOutput("rdata",    {24'd0, bus4.mem_rdata},    {24'd0, e.rdata});
                checkOutput("portAddr", bus4.port_addr,             e.portAddr);
`ifdef SWITCH_MEM_CFG_PARITY_EN
                checkOutput("perr",     {31'd0, bus4.mem_perr},     {31'd0, e.perr});
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        bus4.mem_en = 1'b0; bus4.mem_rd_wr = 1'b0; bus4.mem_addr = '0;
        bus4.mem_wdata = '0; bus4.cfg_lock = 1'b0;
        bus3.mem_en = 1'b0; bus3.mem_rd_wr = 1'b0; bus3.mem_addr = '0;
        bus3.mem_wdata = '0; bus3.cfg_lock = 1'b0;
`ifdef SWITCH_MEM_CFG_PARITY_EN
        bus4.parity_inject = 1'b0;
        bus3.parity_inject = 1'b0;
`endif
        modelReset();
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        checkOutput("rstRdata",    {24'd0, bus4.mem_rdata},    32'h0);
        checkOutput("rstRvalid",   {31'd0, bus4.mem_rvalid},   32'h0);
        checkOutput("rstErr",      {31'd0, bus4.mem_err},      32'h0);
        checkOutput("rstUpdate",   {31'd0, bus4.cfg_update},   32'h0);
        checkOutput("rstConflict", {31'd0, bus4.cfg_conflict}, 32'h0);
        checkOutput("rstPortAddr", bus4.port_addr,             32'h03020100);
        checkOutput("rstPortAddr3", {8'd0, bus3.port_addr},    32'h00020100);

        scoreOn = 1'b1;
        for (int a = 0; a < 4; a++) applyStimulus(1'b1, 1'b0, 2'(a), 8'h00, 1'b0, 1'b0);
        idleCycles(2);

        applyStimulus(1'b1, 1'b1, 2'd2, 8'hA5, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 2'd2, 8'h00, 1'b0, 1'b0);
        idleCycles(2);

        applyStimulus(1'b1, 1'b1, 2'd1, 8'h11, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 2'd1, 8'h00, 1'b1, 1'b0);
        idleCycles(2);

        applyStimulus(1'b1, 1'b1, 2'd0, 8'h03, 1'b0, 1'b0);
        idleCycles(2);
        applyStimulus(1'b1, 1'b1, 2'd0, 8'h07, 1'b0, 1'b0);
        idleCycles(2);

        applyStimulus(1'b1, 1'b1, 2'd3, 8'h3C, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 2'd3, 8'h3C, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 2'd3, 8'h00, 1'b1, 1'b0);
        idleCycles(2);

        for (int k = 0; k < 40; k++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                          2'($urandom_range(0, 3)), 8'($urandom_range(0, 7)),
                          1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
        end
        idleCycles(2);

`ifdef SWITCH_MEM_CFG_PARITY_EN
        applyStimulus(1'b1, 1'b1, 2'd1, 8'h5A, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 2'd1, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 2'd2, 8'h5B, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 2'd2, 8'h00, 1'b0, 1'b0);
        idleCycles(2);
`endif

        // Reset lands between a read request and its response edge.
        applyStimulus(1'b1, 1'b0, 2'd1, 8'h00, 1'b0, 1'b0);
        @(negedge clock);
        #2;
        reset = 1'b1;
        scoreOn = 1'b0;
        sbQ.delete();
        bus4.mem_en = 1'b0;
        #1;
        checkOutput("midRstRvalid",   {31'd0, bus4.mem_rvalid},   32'h0);
        checkOutput("midRstRdata",    {24'd0, bus4.mem_rdata},    32'h0);
        checkOutput("midRstErr",      {31'd0, bus4.mem_err},      32'h0);
        checkOutput("midRstUpdate",   {31'd0, bus4.cfg_update},   32'h0);
        checkOutput("midRstConflict", {31'd0, bus4.cfg_conflict}, 32'h0);
        checkOutput("midRstPortAddr", bus4.port_addr,             32'h03020100);
`ifdef SWITCH_MEM_CFG_PARITY_EN
        checkOutput("midRstPerr",     {31'd0, bus4.mem_perr},     32'h0);
`endif
        @(posedge clock);
        #1;
        checkOutput("postRstRvalid", {31'd0, bus4.mem_rvalid}, 32'h0);
        reset = 1'b0;
        modelReset();
        scoreOn = 1'b1;
        applyStimulus(1'b1, 1'b0, 2'd1, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
        idleCycles(2);

        // Three-entry instance: address 3 is out of range.
        @(posedge clock);
        #1;
        bus3.mem_en = 1'b1; bus3.mem_rd_wr = 1'b0; bus3.mem_addr = 2'd3;
        @(posedge clock);
        #1;
        checkOutput("oorRdRvalid", {31'd0, bus3.mem_rvalid}, 32'h1);
        checkOutput("oorRdRdata",  {24'd0, bus3.mem_rdata},  32'h0);
        checkOutput("oorRdErr",    {31'd0, bus3.mem_err},    32'h1);
        bus3.mem_rd_wr = 1'b1; bus3.mem_wdata = 8'h55;
        @(posedge clock);
        #1;
        checkOutput("oorWrErr",    {31'd0, bus3.mem_err},    32'h1);
        checkOutput("oorWrUpdate", {31'd0, bus3.cfg_update}, 32'h0);
        checkOutput("oorWrRvalid", {31'd0, bus3.mem_rvalid}, 32'h0);
        bus3.mem_rd_wr = 1'b0; bus3.mem_addr = 2'd2;
        @(posedge clock);
        #1;
        checkOutput("inRdRvalid",  {31'd0, bus3.mem_rvalid}, 32'h1);
        checkOutput("inRdRdata",   {24'd0, bus3.mem_rdata},  32'h2);
        checkOutput("inRdErr",     {31'd0, bus3.mem_err},    32'h0);
        checkOutput("portAddr3",   {8'd0, bus3.port_addr},   32'h00020100);
        bus3.mem_en = 1'b0;
        @(posedge clock);
        #1;
        checkOutput("idleRvalid3", {31'd0, bus3.mem_rvalid}, 32'h0);
        checkOutput("idleErr3",    {31'd0, bus3.mem_err},    32'h0);
        checkOutput("holdRdata3",  {24'd0, bus3.mem_rdata},  32'h2);

        repeat (2) @(posedge clock);
        checkOutput("sbDrained", sbQ.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
